// File: rtl/ov5640_capture.sv
// ov5640_capture: OV5640 DVP capture, drops start-up frames, packs byte pairs into RGB565 pixels.
// Latency: 2 pclk from the second byte of a pair at the pins to dip_en/dip_data.
// Backpressure: none; the sensor cannot be stalled, pixels stream out at the DVP byte rate / 2.

module ov5640_capture #(
  parameter int FRAME_SKIP = 10,
  parameter int H_PIXEL    = 640,
  parameter int V_PIXEL    = 480
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        cfg_done,
  input  logic        ov_vsync,
  input  logic        ov_href,
  input  logic [7:0]  ov_data,
  output logic        dip_en,
  output logic [15:0] dip_data,
  output logic        frame_start,
  output logic        line_err,
  output logic        frame_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SKIP   = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  localparam bit          NO_SKIP  = (FRAME_SKIP == 0);
  localparam logic [8:0]  SKIP_TGT = FRAME_SKIP[8:0];
  localparam logic [11:0] H_TGT    = H_PIXEL[11:0];
  localparam logic [10:0] V_TGT    = V_PIXEL[10:0];

  state_t      state_q, state_d;

  logic        vs_r1_q, vs_r2_q;
  logic        href_r1_q, href_r2_q;
  logic [7:0]  data_r1_q;

  logic [7:0]  skip_cnt_q, skip_cnt_d;
  logic        phase_q, phase_d;
  logic [7:0]  hi_q, hi_d;
  logic [11:0] pix_cnt_q, pix_cnt_d;
  logic [10:0] line_cnt_q, line_cnt_d;
  logic [10:0] line_next;

  logic        dip_en_q, dip_en_d;
  logic [15:0] dip_data_q, dip_data_d;
  logic        frame_start_q, frame_start_d;
  logic        line_err_q, line_err_d;
  logic        frame_err_q, frame_err_d;

  logic        vs_rise;
  logic        href_fall;
  logic        skip_hit;
  logic        entry;

  // Register the DVP pins once; vsync and href get a second stage for edge detection.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_r1_q   <= 1'b0;
      vs_r2_q   <= 1'b0;
      href_r1_q <= 1'b0;
      href_r2_q <= 1'b0;
      data_r1_q <= 8'h00;
    end else begin
      vs_r1_q   <= ov_vsync;
      vs_r2_q   <= vs_r1_q;
      href_r1_q <= ov_href;
      href_r2_q <= href_r1_q;
      data_r1_q <= ov_data;
    end
  end

  assign vs_rise   = vs_r1_q & ~vs_r2_q;
  assign href_fall = href_r2_q & ~href_r1_q;
  assign skip_hit  = (({1'b0, skip_cnt_q} + 9'd1) == SKIP_TGT);
  // The vsync edge that leaves SKIP (or IDLE when nothing is skipped) also opens the first frame.
  assign entry     = cfg_done && vs_rise &&
                     (((state_q == S_IDLE) && NO_SKIP) || ((state_q == S_SKIP) && skip_hit));

  // FSM state register.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: losing cfg_done always returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (!cfg_done) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (NO_SKIP) begin
            if (vs_rise) state_d = S_ACTIVE;
          end else begin
            state_d = S_SKIP;
          end
        end
        S_SKIP:   if (vs_rise && skip_hit) state_d = S_ACTIVE;
        S_ACTIVE: state_d = S_ACTIVE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs and datapath: skip counting, byte pairing, line/frame geometry checks.
  always_comb begin
    skip_cnt_d    = skip_cnt_q;
    phase_d       = phase_q;
    hi_d          = hi_q;
    pix_cnt_d     = pix_cnt_q;
    line_cnt_d    = line_cnt_q;
    line_next     = line_cnt_q;
    dip_en_d      = 1'b0;
    dip_data_d    = dip_data_q;
    frame_start_d = 1'b0;
    line_err_d    = 1'b0;
    frame_err_d   = 1'b0;

    if (!cfg_done) begin
      // Gating on the live level also suppresses a pixel whose second byte lands this cycle.
      skip_cnt_d = 8'd0;
      phase_d    = 1'b0;
      pix_cnt_d  = 12'd0;
      line_cnt_d = 11'd0;
    end else if (state_q != S_ACTIVE) begin
      phase_d    = 1'b0;
      pix_cnt_d  = 12'd0;
      line_cnt_d = 11'd0;
      if (state_q == S_IDLE) begin
        skip_cnt_d = 8'd0;
      end else if (vs_rise && (skip_cnt_q != 8'hFF)) begin
        skip_cnt_d = skip_cnt_q + 8'd1;
      end
      if (entry) frame_start_d = 1'b1;
    end else begin
      if (href_r1_q) begin
        phase_d = ~phase_q;
        if (!phase_q) begin
          hi_d = data_r1_q;
        end else begin
          dip_en_d   = 1'b1;
          dip_data_d = {hi_q, data_r1_q};
          if (pix_cnt_q != 12'hFFF) pix_cnt_d = pix_cnt_q + 12'd1;
        end
      end else begin
        // Realign so every line begins on a high byte; an orphan high byte is dropped.
        phase_d = 1'b0;
      end

      if (href_fall) begin
        line_err_d = (pix_cnt_q != H_TGT) || phase_q;
        if (line_cnt_q != 11'h7FF) line_next = line_cnt_q + 11'd1;
        pix_cnt_d = 12'd0;
      end
      line_cnt_d = line_next;

      // Frame check sees the line that may have closed in this same cycle.
      if (vs_rise) begin
        frame_start_d = 1'b1;
        frame_err_d   = (line_next != V_TGT);
        line_cnt_d    = 11'd0;
        pix_cnt_d     = 12'd0;
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      skip_cnt_q    <= 8'd0;
      phase_q       <= 1'b0;
      hi_q          <= 8'h00;
      pix_cnt_q     <= 12'd0;
      line_cnt_q    <= 11'd0;
      dip_en_q      <= 1'b0;
      dip_data_q    <= 16'h0000;
      frame_start_q <= 1'b0;
      line_err_q    <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      skip_cnt_q    <= skip_cnt_d;
      phase_q       <= phase_d;
      hi_q          <= hi_d;
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      dip_en_q      <= dip_en_d;
      dip_data_q    <= dip_data_d;
      frame_start_q <= frame_start_d;
      line_err_q    <= line_err_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign dip_en      = dip_en_q;
  assign dip_data    = dip_data_q;
  assign frame_start = frame_start_q;
  assign line_err    = line_err_q;
  assign frame_err   = frame_err_q;

endmodule
